// File: rtl/fcore_alu_dispatcher.sv
// fcore ALU dispatcher: a single issue port fans out to N_UNITS fixed-latency
// FP units, and their results merge onto one result stream. A writeback
// reservation scoreboard makes sure no two results reach the merge point in
// the same cycle. Each result is tagged with its destination, and lost,
// spurious and illegal operations raise sticky error flags.
module fcore_alu_dispatcher #(
    parameter int DATA_WIDTH  = 32,
    parameter int USER_WIDTH  = 16,
    parameter int N_UNITS     = 5,
    parameter int SUBOP_WIDTH = 2,
    parameter int MAX_LATENCY = 16,
    // unit i latency lives in slice [5*i +: 5]; unit 0 is the least significant slice
    parameter logic [5*N_UNITS-1:0] UNIT_LATENCY = {5'd14, 5'd2, 5'd6, 5'd6, 5'd8}
) (
    input  logic                          clock,
    input  logic                          reset,
    // operand A stream, user carries the destination tag
    input  logic [DATA_WIDTH-1:0]         operand_a_data,
    input  logic [USER_WIDTH-1:0]         operand_a_user,
    input  logic                          operand_a_valid,
    output logic                          operand_a_ready,
    // operand B stream
    input  logic [DATA_WIDTH-1:0]         operand_b_data,
    input  logic                          operand_b_valid,
    output logic                          operand_b_ready,
    // operation stream: {subop, unit_idx[2:0]}
    input  logic [3+SUBOP_WIDTH-1:0]      operation_data,
    input  logic                          operation_valid,
    output logic                          operation_ready,
    // merged result stream; ready is not honoured (the register file always accepts)
    output logic [DATA_WIDTH-1:0]         result_data,
    output logic [USER_WIDTH-1:0]         result_user,
    output logic                          result_valid,
    input  logic                          result_ready,
    // functional unit side
    output logic [N_UNITS-1:0]            unit_valid,
    output logic [DATA_WIDTH-1:0]         unit_a,
    output logic [DATA_WIDTH-1:0]         unit_b,
    output logic [SUBOP_WIDTH-1:0]        unit_subop,
    input  logic [N_UNITS*DATA_WIDTH-1:0] unit_res_data,
    input  logic [N_UNITS-1:0]            unit_res_valid,
    // status
    output logic [4:0]                    in_flight,
    output logic                          err_lost,
    output logic                          err_spurious,
    output logic                          err_bad_op,
    input  logic                          clear_errors
);

    localparam int SB_W = MAX_LATENCY + 2;
    localparam int OP_W = 3 + SUBOP_WIDTH;

    // scoreboard and tag pipe; both move one step toward index 0 every cycle
    logic [SB_W-1:0]       sb_reg, sb_next;
    logic [USER_WIDTH-1:0] tag_pipe_reg [SB_W];
    logic [USER_WIDTH-1:0] tag_pipe_next [SB_W];
    logic [2:0]            idx_pipe_reg [SB_W];
    logic [2:0]            idx_pipe_next [SB_W];

    logic [4:0]            in_flight_reg, in_flight_next;
    logic                  err_lost_reg, err_spurious_reg, err_bad_op_reg;

    // decode of the offered operation
    logic [2:0]             op_idx;
    logic [SUBOP_WIDTH-1:0] op_subop;
    logic                   op_idx_ok;
    logic [SB_W-1:0]        op_mask;
    logic [N_UNITS-1:0]     op_onehot;

    logic slot_free, in_ready, fire, issue, bad_fire;

    // capture side
    logic                  cap_active, cap_hit, cap_lost, cap_spurious;
    logic [2:0]            cap_idx;
    logic [N_UNITS-1:0]    cap_onehot;
    logic [DATA_WIDTH-1:0] cap_data;

    // writeback slot each unit reserves, expressed in the current (unshifted) frame
    logic [SB_W-1:0] unit_slot_mask [N_UNITS];

    genvar gi;
    generate
        for (gi = 0; gi < N_UNITS; gi++) begin : g_slot_mask
            assign unit_slot_mask[gi] = SB_W'(1) << (UNIT_LATENCY[5*gi +: 5] + 5'd1);
        end
    endgenerate

    // look up the target unit's reservation slot; unknown units reserve nothing
    always_comb begin
        op_idx    = operation_data[2:0];
        op_subop  = operation_data[OP_W-1:3];
        op_idx_ok = 1'b0;
        op_mask   = '0;
        op_onehot = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (op_idx == 3'(i)) begin
                op_idx_ok    = 1'b1;
                op_mask      = unit_slot_mask[i];
                op_onehot[i] = 1'b1;
            end
        end
    end

    // a bad op has an empty mask, so it is always free and gets consumed
    assign slot_free       = ~|(sb_reg & op_mask);
    assign in_ready        = reset & slot_free;
    assign operand_a_ready = in_ready;
    assign operand_b_ready = in_ready;
    assign operation_ready = in_ready;

    assign fire     = operand_a_valid & operand_b_valid & operation_valid & in_ready;
    assign issue    = fire & op_idx_ok;
    assign bad_fire = fire & ~op_idx_ok;

    // match the reservation reaching slot 0 against the expected unit strobe
    always_comb begin
        cap_active = sb_reg[0];
        cap_idx    = idx_pipe_reg[0];
        cap_hit    = 1'b0;
        cap_onehot = '0;
        cap_data   = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (cap_idx == 3'(i)) begin
                cap_onehot[i] = cap_active;
                cap_hit       = cap_active & unit_res_valid[i];
                cap_data      = unit_res_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        cap_lost     = cap_active & ~cap_hit;
        cap_spurious = |(unit_res_valid & ~cap_onehot);
    end

    // reserve the new slot, then shift everything one step toward the writeback end
    assign sb_next = (sb_reg | (issue ? op_mask : '0)) >> 1;

    generate
        for (gi = 0; gi < SB_W - 1; gi++) begin : g_tag_shift
            assign tag_pipe_next[gi] = (issue && op_mask[gi+1]) ? operand_a_user : tag_pipe_reg[gi+1];
            assign idx_pipe_next[gi] = (issue && op_mask[gi+1]) ? op_idx         : idx_pipe_reg[gi+1];
        end
    endgenerate
    assign tag_pipe_next[SB_W-1] = '0;
    assign idx_pipe_next[SB_W-1] = '0;

    // issue and retire on the same cycle cancel out
    always_comb begin
        in_flight_next = in_flight_reg;
        case ({issue, sb_reg[0]})
            2'b10:   in_flight_next = in_flight_reg + 5'd1;
            2'b01:   in_flight_next = in_flight_reg - 5'd1;
            default: in_flight_next = in_flight_reg;
        endcase
    end

    // scoreboard, tag pipe and outstanding count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb_reg        <= '0;
            in_flight_reg <= '0;
            for (int k = 0; k < SB_W; k++) begin
                tag_pipe_reg[k] <= '0;
                idx_pipe_reg[k] <= '0;
            end
        end else begin
            sb_reg        <= sb_next;
            in_flight_reg <= in_flight_next;
            for (int k = 0; k < SB_W; k++) begin
                tag_pipe_reg[k] <= tag_pipe_next[k];
                idx_pipe_reg[k] <= idx_pipe_next[k];
            end
        end
    end

    // registered issue stage: one-cycle strobe, operand buses hold between issues
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            unit_valid <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            unit_subop <= '0;
        end else begin
            unit_valid <= issue ? op_onehot : '0;
            if (issue) begin
                unit_a     <= operand_a_data;
                unit_b     <= operand_b_data;
                unit_subop <= op_subop;
            end
        end
    end

    // registered result merge; data and tag hold when no result is produced
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_valid <= 1'b0;
            result_data  <= '0;
            result_user  <= '0;
        end else begin
            result_valid <= cap_hit;
            if (cap_hit) begin
                result_data <= cap_data;
                result_user <= tag_pipe_reg[0];
            end
        end
    end

    // sticky error flags; a new error beats a simultaneous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_lost_reg     <= 1'b0;
            err_spurious_reg <= 1'b0;
            err_bad_op_reg   <= 1'b0;
        end else begin
            err_lost_reg     <= cap_lost     | (err_lost_reg     & ~clear_errors);
            err_spurious_reg <= cap_spurious | (err_spurious_reg & ~clear_errors);
            err_bad_op_reg   <= bad_fire     | (err_bad_op_reg   & ~clear_errors);
        end
    end

    assign in_flight    = in_flight_reg;
    assign err_lost     = err_lost_reg;
    assign err_spurious = err_spurious_reg;
    assign err_bad_op   = err_bad_op_reg;

    // the result stream has no backpressure, so ready is intentionally unused
    logic unused_result_ready;
    assign unused_result_ready = result_ready;

endmodule
